// File: rtl/fetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_buffer_if                                                            |
// | Instruction-memory request/acknowledge bus between fetch and memory.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_buffer                                                               |
// | IF stage: issues PC to imem, buffers 2 returned instructions for decode.   |
// | Optional macro FETCH_BYPASS_EN: 0-cycle forwarding of an ack into an empty |
// | buffer.                                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [ADDR_W-1:0] direinstru,
    input  wire logic [ADDR_W-1:0] sum2sumout,
    output logic                   pc_stall,
    fetch_buffer_if.master         imem,
    input  wire logic              flush,
    input  wire logic              id_stall,
    output logic [DATA_W-1:0]      instru,
    output logic [ADDR_W-1:0]      sum2sumin,
    output logic                   id_valid
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_KILL = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [ADDR_W-1:0] r_buf_pc   [2];
    logic [1:0]        r_count;

    logic              w_req_idle;
    logic              w_req;
    logic              w_accept;
    logic              w_bypass;
    logic              w_pop;
    logic              w_shift;
    logic              w_store;
    logic [1:0]        w_wr_cnt;
    logic [1:0]        w_count_nxt;

    // Gated by reset so the bus and pc_stall sit at their idle values while held in reset.
    assign w_req_idle = reset && (r_state == c_IDLE) && (r_count != 2'd2) && !flush;
    assign w_req      = w_req_idle || ((r_state == c_REQ) && !flush);
    assign w_accept   = w_req && imem.imem_ack;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_req_idle ? direinstru : r_addr;
    assign pc_stall       = !reset || !(w_accept || flush);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_accept && (r_count == 2'd0);
`else
    assign w_bypass = 1'b0;
`endif

    assign id_valid  = (r_count != 2'd0) || w_bypass;
    assign instru    = w_bypass ? imem.imem_data : r_buf_data[0];
    assign sum2sumin = w_bypass ? sum2sumout     : r_buf_pc[0];

    // A bypassed instruction that decode takes immediately never enters the buffer.
    assign w_pop       = id_valid && !id_stall;
    assign w_shift     = w_pop && (r_count != 2'd0);
    assign w_store     = w_accept && !(w_bypass && w_pop);
    assign w_wr_cnt    = r_count - {1'b0, w_shift};
    assign w_count_nxt = w_wr_cnt + {1'b0, w_store};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_req_idle && !imem.imem_ack) w_state_nxt = c_REQ;
            c_REQ: begin
                if (imem.imem_ack)  w_state_nxt = c_IDLE;
                else if (flush)     w_state_nxt = c_KILL;
            end
            c_KILL: if (imem.imem_ack) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_idle && !imem.imem_ack) r_addr <= direinstru;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count       <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_pc[0]   <= '0;
            r_buf_pc[1]   <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_shift) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_pc[0]   <= r_buf_pc[1];
            end
            // A store into slot 0 follows the shift and so wins over it.
            if (w_store) begin
                r_buf_data[w_wr_cnt[0]] <= imem.imem_data;
                r_buf_pc[w_wr_cnt[0]]   <= sum2sumout;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch stage placed directly downstream of the `pc` block. It issues the current PC value to instruction memory over a req/ack handshake and holds the PC while a fetch is outstanding. Returned instructions go into a 2-entry buffer paired with their PC+1. The buffer head feeds the decode stage (IF/ID boundary) and supports decode stall and branch flush.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `direinstru`  in  ADDR_W  current PC from `pc`
- `sum2sumout`  in  ADDR_W  PC+1 from `pc`
- `pc_stall`  out  1  high: `pc` must hold its value this cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req` high
- `imem_ack`  in  1  memory has accepted the request; `imem_data` valid this cycle
- `imem_data`  in  DATA_W  fetched instruction
- `flush`  in  1  taken branch/jump; discard everything fetched
- `id_stall`  in  1  decode cannot accept this cycle
- `instru`  out  DATA_W  instruction to decode (buffer head)
- `sum2sumin`  out  ADDR_W  PC+1 of `instru`, used by the branch adder
- `id_valid`  out  1  `instru`/`sum2sumin` valid

## Operation
- FSM states: IDLE, REQ, KILL. Reset state: IDLE.
- IDLE:
  - If count<2 and !flush: drive `imem_req`=1 and `imem_addr`=`direinstru` combinationally.
  - If `imem_ack` arrives in the same cycle: accept the fetch and stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - Hold `imem_req`=1 and the latched `imem_addr`.
  - On `imem_ack`: accept the fetch and go to IDLE.
- Accepting a fetch means pushing {`imem_data`, `sum2sumout`} into the buffer.
- Only one fetch is ever outstanding. A request is issued only when count<2, so an accepted fetch always has room.
- Pop: `id_valid` && !`id_stall`. Push and pop may occur in the same cycle; count is then unchanged.
- `pc_stall` = 0 only in the cycle a fetch is accepted, or in a `flush` cycle (so `pc` loads its target). Otherwise it is 1.
- Flush:
  - Buffer is cleared at the next edge.
  - A fetch acked in the flush cycle is dropped.
  - If a request is pending without ack: drop `imem_req` and go to KILL. KILL waits for `imem_ack`, discards that data, then returns to IDLE. `pc_stall` is 1 while in KILL.
  - If IDLE with no request: stay IDLE.
- Reset values:
  - `imem_req`=0, `imem_addr`=0, `id_valid`=0, `instru`=0, `sum2sumin`=0, `pc_stall`=1.
  - Buffer count=0.
- `imem_ack` is ignored while `imem_req`=0 outside KILL.

## Timing
- Zero-wait memory (ack in the request cycle): PC sampled in cycle N, `id_valid`=1 in cycle N+1. Sustained throughput is 1 instruction/cycle with no `id_stall`.
- With k wait cycles, the ack arrives at N+k and `id_valid` rises at N+k+1.
- `flush` in cycle N: `id_valid`=0 in cycle N+1. The first post-flush request is issued in cycle N+1, or after the KILL ack.
- Reset deasserting mid-transfer: the memory must abort. Any stale ack seen in IDLE is ignored.
- `id_stall` with the buffer full: no new request; `pc_stall`=1 until a pop frees an entry. The request is issued the cycle after the pop.

## Configuration
- `FETCH_BYPASS_EN` defined: when the buffer is empty and a fetch is accepted, `instru`/`sum2sumin`/`id_valid` show `imem_data`/`sum2sumout` combinationally in the ack cycle (0-cycle latency).
  - If it is popped that cycle, it is not written into the buffer.
  - A flush in that cycle still forces `id_valid`=0.
- Not defined: outputs come only from buffer registers; latency is ack+1.

## Test plan
- Zero-wait memory, PC 0,1,2,…, no stall:
  - `id_valid` is high every cycle from cycle 1.
  - `instru` = mem[0], mem[1], … and `sum2sumin` = 1, 2, …
- Memory acks after 3 cycles:
  - `imem_req` and `imem_addr`=5 are held for 3 cycles and `pc_stall`=1 throughout.
  - `pc_stall`=0 in the ack cycle; `id_valid` rises the cycle after.
- `id_stall` held 4 cycles:
  - Buffer fills to 2, then `imem_req`=0 and `pc_stall`=1.
  - After release, instructions are delivered in order with none lost or duplicated.
- `flush` while a request to address 7 is pending:
  - FSM enters KILL and the late ack data is discarded.
  - The next delivered instruction is from the new PC (e.g. 0x20), with `sum2sumin`=0x21.
- `reset` pulled low while the buffer is full and REQ is pending:
  - All outputs go to reset values immediately.
  - After release, the first fetch uses the current `direinstru`.
- `FETCH_BYPASS_EN` defined, empty buffer, zero-wait memory: `id_valid`=1 in the same cycle as the ack.
